ep_tx_fifo: RTL and testbench
=============================

// Module: ep_tx_fifo
// PURPOSE
// Per-endpoint transmit FIFO. One instance per endpoint (EP0..EP3) sits directly upstream
// of the endpoint FIFO mux. The bus side writes bytes; the USB side reads bytes through the
// mux via REn/Data/Empty. Provides fill count, flush and sticky error flags.
// PARAMETERS
// FIFO_DEPTH   64  number of byte entries; power of two, 4..1024
// ADDR_WIDTH   6   log2(FIFO_DEPTH); must be consistent with FIFO_DEPTH
// PORTS
// clk               in   1             system clock, all logic on rising edge
// rst               in   1             synchronous reset, active-low (0 = reset)
// fifoWEn           in   1             bus-side write strobe, one byte per cycle
// fifoWData         in   8             bus-side write data
// fifoFull          out  1             no free entry
// fifoREn           in   1             USB-side read strobe (from mux TxFifoEPnREn)
// fifoRData         out  8             read data (to mux TxFifoEPnData)
// fifoEmpty         out  1             no stored entry (to mux TxFifoEPnEmpty)
// fifoFlush         in   1             discard all contents
// numElementsInFifo out  ADDR_WIDTH+1  current fill count, 0..FIFO_DEPTH
// overflow          out  1             sticky: write attempted while full
// underflow         out  1             sticky: read attempted while empty
// clrErr            in   1             clears overflow and underflow
// BEHAVIOUR
// - Reset (rst=0 at clk edge): wrPtr=rdPtr=0, count=0, fifoEmpty=1, fifoFull=0,
//   fifoRData=8'h00, overflow=0, underflow=0. Memory contents not reset.
// - Pointers ADDR_WIDTH+1 bits; MSB is wrap bit. Empty when pointers equal; full when
//   low bits equal and MSBs differ. Flags and count are registered, valid the cycle after
//   the update edge; no combinational path from strobes to flags.
// - Write: on edge with fifoWEn=1 and fifoFull=0 -> mem[wrPtr]<=fifoWData, wrPtr+1, count+1.
//   fifoWEn=1 with fifoFull=1 -> byte dropped, state unchanged, overflow<=1.
// - Read: registered, latency 1. On edge with fifoREn=1 and fifoEmpty=0 ->
//   fifoRData<=mem[rdPtr], rdPtr+1, count-1. Data valid the cycle after the strobe.
//   fifoREn=1 with fifoEmpty=1 -> fifoRData holds, underflow<=1.
//   fifoRData holds its last value when no read occurs.
// - Simultaneous read+write, not empty/full: both occur, count unchanged.
//   When full: both occur (read frees slot same edge), count stays FIFO_DEPTH, no overflow.
//   When empty: write accepted, read rejected, underflow<=1, count becomes 1.
// - Flags evaluated against registered state before the edge, never post-update values.
// - fifoFlush=1: highest priority below reset; wrPtr<=rdPtr (pointers equal), count<=0,
//   empty<=1, full<=0; same-edge write and read ignored, no error flags set;
//   fifoRData holds.
// - clrErr=1 clears overflow/underflow; a new error on the same edge wins (flag set).
// - Pointer wrap at FIFO_DEPTH is natural binary roll-over; count never exceeds
//   FIFO_DEPTH and never goes below 0.
// - Reset mid-transfer discards contents immediately; first read after reset returns
//   the first byte written after reset.
// TESTING
// 1 Reset: rst=0 one cycle -> fifoEmpty=1, fifoFull=0, count=0, fifoRData=8'h00, errors 0.
// 2 Write 8'hA5,8'h3C, then REn 2 cycles -> fifoRData=8'hA5 then 8'h3C, each one cycle
//   after strobe; count 2->1->0; fifoEmpty=1 after second read.
// 3 Write 64 bytes (0..63) -> fifoFull=1, count=64; 65th write (8'hFF) -> overflow=1,
//   count stays 64; read all 64 -> data 0..63 in order, no 8'hFF.
// 4 Full FIFO, WEn+REn same edge -> count=64, overflow=0, read returns oldest byte;
//   empty FIFO, WEn+REn -> count=1, underflow=1; clrErr -> underflow=0.
// 5 Fill 10, read 10, repeat 20 times (pointer wrap) -> data order intact, count returns 0.
// 6 Fill 5, assert fifoFlush with WEn=1 -> count=0, fifoEmpty=1, no overflow; then rst=0
//   mid-fill of 3 bytes -> count=0, next written byte is next read byte.

Source files
------------

// File: rtl/ep_tx_fifo.sv
// Per-endpoint transmit byte FIFO: the bus side writes and the USB side reads through the endpoint mux.
// Read data, fill count, full/empty and sticky error flags are all registered.
module ep_tx_fifo #(
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifoWEn,
  input  logic [7:0]            fifoWData,
  output logic                  fifoFull,
  input  logic                  fifoREn,
  output logic [7:0]            fifoRData,
  output logic                  fifoEmpty,
  input  logic                  fifoFlush,
  output logic [ADDR_WIDTH:0]   numElementsInFifo,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clrErr
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [7:0]          mem [FIFO_DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                do_wr, do_rd;

  // Strobe semantics: a byte moves on every edge where its strobe is high and the
  // registered flag allows it; a refused strobe drops nothing silently but sets a sticky error.
  // A read on a full FIFO frees the slot the same edge, so a simultaneous write is accepted.
  always_comb begin
    do_rd       = fifoREn && !empty_q && !fifoFlush;
    do_wr       = fifoWEn && (!full_q || fifoREn) && !fifoFlush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rdata_d     = rdata_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clrErr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    if (fifoFlush) begin
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        rdata_d  = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
      if (fifoWEn && full_q && !fifoREn) overflow_d = 1'b1;
      if (fifoREn && empty_q) underflow_d = 1'b1;
    end

    count_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
              (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      rdata_q     <= 8'h00;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      rdata_q     <= rdata_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (rst && do_wr) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= fifoWData;
  end

  assign fifoFull          = full_q;
  assign fifoEmpty         = empty_q;
  assign fifoRData         = rdata_q;
  assign numElementsInFifo = count_q;
  assign overflow          = overflow_q;
  assign underflow         = underflow_q;

endmodule

// File: tb/tb_ep_tx_fifo.sv
// Directed self-checking bench for ep_tx_fifo: reset, basic order, full/overflow,
// simultaneous access, pointer wrap, flush and mid-fill reset.
module tb_ep_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifoWEn;
  logic [7:0] fifoWData;
  logic       fifoFull;
  logic       fifoREn;
  logic [7:0] fifoRData;
  logic       fifoEmpty;
  logic       fifoFlush;
  logic [6:0] numElementsInFifo;
  logic       overflow;
  logic       underflow;
  logic       clrErr;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];

  ep_tx_fifo #(.FIFO_DEPTH(64), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .fifoWEn(fifoWEn), .fifoWData(fifoWData), .fifoFull(fifoFull),
    .fifoREn(fifoREn), .fifoRData(fifoRData), .fifoEmpty(fifoEmpty),
    .fifoFlush(fifoFlush), .numElementsInFifo(numElementsInFifo),
    .overflow(overflow), .underflow(underflow), .clrErr(clrErr)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic write_byte(input logic [7:0] d);
    fifoWEn = 1'b1;
    fifoWData = d;
    cycle();
    fifoWEn = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic read_check(input string name);
    logic [7:0] exp;
    exp = exp_q.pop_front();
    fifoREn = 1'b1;
    cycle();
    fifoREn = 1'b0;
    total_cnt++;
    if (fifoRData !== exp) $display("FAIL %s: rdata got %02h want %02h", name, fifoRData, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    fifoWEn = 1'b1;
    write_byte(8'h5A);
    apply_reset();
    total_cnt++;
    if ({fifoEmpty, fifoFull, numElementsInFifo, fifoRData, overflow, underflow} !== {1'b1, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset: empty=%b full=%b cnt=%0d rdata=%02h ovf=%b unf=%b want 1 0 0 00 0 0",
               fifoEmpty, fifoFull, numElementsInFifo, fifoRData, overflow, underflow);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    apply_reset();
    write_byte(8'hA5);
    write_byte(8'h3C);
    total_cnt++;
    if (numElementsInFifo !== 7'd2 || fifoRData !== 8'h00)
      $display("FAIL basic_fill: cnt=%0d rdata=%02h want 2 00", numElementsInFifo, fifoRData);
    else pass_cnt++;
    read_check("basic_rd0");
    total_cnt++;
    if (numElementsInFifo !== 7'd1) $display("FAIL basic_cnt1: got %0d want 1", numElementsInFifo);
    else pass_cnt++;
    read_check("basic_rd1");
    total_cnt++;
    if (numElementsInFifo !== 7'd0 || fifoEmpty !== 1'b1)
      $display("FAIL basic_empty: cnt=%0d empty=%b want 0 1", numElementsInFifo, fifoEmpty);
    else pass_cnt++;
  endtask

  task automatic test_full_overflow();
    apply_reset();
    for (int i = 0; i < 64; i++) write_byte(8'(i));
    total_cnt++;
    if (fifoFull !== 1'b1 || numElementsInFifo !== 7'd64 || overflow !== 1'b0)
      $display("FAIL full: full=%b cnt=%0d ovf=%b want 1 64 0", fifoFull, numElementsInFifo, overflow);
    else pass_cnt++;
    fifoWEn = 1'b1;
    fifoWData = 8'hFF;
    cycle();
    fifoWEn = 1'b0;
    total_cnt++;
    if (overflow !== 1'b1 || numElementsInFifo !== 7'd64)
      $display("FAIL overflow: ovf=%b cnt=%0d want 1 64", overflow, numElementsInFifo);
    else pass_cnt++;
    for (int i = 0; i < 64; i++) read_check("full_drain");
    total_cnt++;
    if (fifoEmpty !== 1'b1 || numElementsInFifo !== 7'd0)
      $display("FAIL full_drained: empty=%b cnt=%0d want 1 0", fifoEmpty, numElementsInFifo);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 64; i++) write_byte(8'(8'h80 + i));
    fifoWEn = 1'b1; fifoREn = 1'b1; fifoWData = 8'h11;
    cycle();
    fifoWEn = 1'b0; fifoREn = 1'b0;
    total_cnt++;
    if (numElementsInFifo !== 7'd64 || overflow !== 1'b0 || fifoRData !== 8'h80 || fifoFull !== 1'b1)
      $display("FAIL full_rw: cnt=%0d ovf=%b rdata=%02h full=%b want 64 0 80 1",
               numElementsInFifo, overflow, fifoRData, fifoFull);
    else pass_cnt++;
    apply_reset();
    fifoWEn = 1'b1; fifoREn = 1'b1; fifoWData = 8'h22;
    cycle();
    fifoWEn = 1'b0; fifoREn = 1'b0;
    total_cnt++;
    if (numElementsInFifo !== 7'd1 || underflow !== 1'b1 || fifoEmpty !== 1'b0 || fifoRData !== 8'h00)
      $display("FAIL empty_rw: cnt=%0d unf=%b empty=%b rdata=%02h want 1 1 0 00",
               numElementsInFifo, underflow, fifoEmpty, fifoRData);
    else pass_cnt++;
    clrErr = 1'b1;
    cycle();
    clrErr = 1'b0;
    total_cnt++;
    if (underflow !== 1'b0) $display("FAIL clr_err: unf=%b want 0", underflow);
    else pass_cnt++;
    exp_q.push_back(8'h22);
    read_check("empty_rw_data");
    clrErr = 1'b1; fifoREn = 1'b1;
    cycle();
    clrErr = 1'b0; fifoREn = 1'b0;
    total_cnt++;
    if (underflow !== 1'b1 || fifoRData !== 8'h22)
      $display("FAIL clr_vs_new_err: unf=%b rdata=%02h want 1 22", underflow, fifoRData);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 10; i++) write_byte(8'(r * 10 + i));
      for (int i = 0; i < 10; i++) read_check("wrap_data");
    end
    total_cnt++;
    if (numElementsInFifo !== 7'd0 || fifoEmpty !== 1'b1 || underflow !== 1'b0)
      $display("FAIL wrap_end: cnt=%0d empty=%b unf=%b want 0 1 0", numElementsInFifo, fifoEmpty, underflow);
    else pass_cnt++;
  endtask

  task automatic test_flush_and_midreset();
    apply_reset();
    for (int i = 0; i < 5; i++) write_byte(8'(8'h60 + i));
    read_check("flush_pre_rd");
    fifoFlush = 1'b1; fifoWEn = 1'b1; fifoWData = 8'h77;
    cycle();
    fifoFlush = 1'b0; fifoWEn = 1'b0;
    exp_q.delete();
    total_cnt++;
    if (numElementsInFifo !== 7'd0 || fifoEmpty !== 1'b1 || overflow !== 1'b0 || fifoRData !== 8'h60)
      $display("FAIL flush: cnt=%0d empty=%b ovf=%b rdata=%02h want 0 1 0 60",
               numElementsInFifo, fifoEmpty, overflow, fifoRData);
    else pass_cnt++;
    write_byte(8'h31);
    write_byte(8'h32);
    fifoWEn = 1'b1; fifoWData = 8'h33;
    apply_reset();
    fifoWEn = 1'b0;
    total_cnt++;
    if (numElementsInFifo !== 7'd0 || fifoEmpty !== 1'b1)
      $display("FAIL midreset: cnt=%0d empty=%b want 0 1", numElementsInFifo, fifoEmpty);
    else pass_cnt++;
    write_byte(8'h44);
    read_check("midreset_first");
  endtask

  initial begin
    rst = 1'b0; fifoWEn = 1'b0; fifoWData = 8'h00; fifoREn = 1'b0;
    fifoFlush = 1'b0; clrErr = 1'b0;
    test_reset();
    test_basic();
    test_full_overflow();
    test_simultaneous();
    test_wrap();
    test_flush_and_midreset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
